sccb_arbiter: RTL and testbench

- Shares the single SCCB register-access engine (`sccb_ctrl` rreq/wreq/com_done port) between several requesters, e.g. the UART debug bridge and an on-chip auto-exposure tuner.
- Arbitration is round-robin. Grants are held off until camera init completes.
- Each accepted command is sequenced through to a one-cycle response pulse.
- Sits between the requesters and `sccb_ctrl` in the clk25 domain.

---
 rtl/sccb_arb_pkg.sv | 12 +
 rtl/sccb_arbiter_rr_pick.sv | 21 ++
 rtl/sccb_arbiter.sv | 125 ++++++++++++
 tb/tb_sccb_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the SCCB command arbiter.
package sccb_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int SCCB_AW             = 8;
  localparam int SCCB_DW             = 8;
  localparam int TIMEOUT_CYC_DEFAULT = 65535;
endpackage

// File: rtl/sccb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_grant, wrapping.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   grant,
  output logic            any_req
);
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any_req && req[(int'(last_grant) + k) % NREQ]) begin
        any_req = 1'b1;
        grant   = IW'((int'(last_grant) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one sccb_ctrl engine among NREQ requesters (clk25 domain).
// Optional WAIT-state timeout is enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                    clk25,
  input  logic                    RESETn,
  input  logic                    init_done,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*SCCB_AW-1:0] req_addr,
  input  logic [NREQ*SCCB_DW-1:0] req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [SCCB_DW-1:0]      rsp_rdata,
  output logic                    rsp_err,
  output logic                    rreq,
  output logic                    wreq,
  output logic [SCCB_AW-1:0]      addr_rw,
  output logic [SCCB_DW-1:0]      data_com,
  input  logic                    com_done,
  input  logic [SCCB_DW-1:0]      data_read,
  output logic                    busy,
  output arb_state_e              state_dbg
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  // Handshake: req_valid is a level held stable until the one-cycle req_ready
  // pulse; rsp_valid is a one-cycle pulse with no backpressure.
  arb_state_e      state;
  logic [IW-1:0]   g;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick_g;
  logic            pick_any;
  logic            cur_wr;
  logic            to_hit;

  assign state_dbg = state;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_g),
    .any_req    (pick_any)
  );

`ifdef SCCB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = (to_cnt == 16'(TIMEOUT_CYC - 1));

  // com_done in the expiry cycle wins, so the error flag is only set without it.
  always_ff @(posedge clk25 or negedge RESETn) begin
    if (!RESETn) begin
      to_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == ST_WAIT) to_cnt <= to_cnt + 16'd1;
      else                  to_cnt <= '0;
      if (state == ST_WAIT && (com_done || to_hit)) rsp_err <= !com_done;
      else if (state == ST_RESP)                    rsp_err <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign to_hit             = 1'b0;
  assign rsp_err            = 1'b0;
`endif

  always_ff @(posedge clk25 or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      g          <= '0;
      last_grant <= IW'(NREQ - 1);
      cur_wr     <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rreq       <= 1'b0;
      wreq       <= 1'b0;
      addr_rw    <= '0;
      data_com   <= '0;
      busy       <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (init_done && pick_any) begin
            g         <= pick_g;
            cur_wr    <= req_wr[pick_g];
            addr_rw   <= req_addr[pick_g*SCCB_AW +: SCCB_AW];
            data_com  <= req_wr[pick_g] ? req_wdata[pick_g*SCCB_DW +: SCCB_DW] : '0;
            wreq      <= req_wr[pick_g];
            rreq      <= !req_wr[pick_g];
            req_ready <= ONE << pick_g;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (com_done || to_hit) begin
            rreq      <= 1'b0;
            wreq      <= 1'b0;
            rsp_valid <= ONE << g;
            rsp_rdata <= (com_done && !cur_wr) ? data_read : '0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= g;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed self-checking bench for sccb_arbiter (NREQ=3, TIMEOUT_CYC=100).
module tb_sccb_arbiter;
  import sccb_arb_pkg::*;

  logic        clk25;
  logic        RESETn;
  logic        init_done;
  logic [2:0]  req_valid;
  logic [2:0]  req_wr;
  logic [23:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rreq;
  logic        wreq;
  logic [7:0]  addr_rw;
  logic [7:0]  data_com;
  logic        com_done;
  logic [7:0]  data_read;
  logic        busy;
  arb_state_e  state_dbg;

  int checks   = 0;
  int failures = 0;

  sccb_arbiter #(.NREQ(3), .TIMEOUT_CYC(100)) dut (
    .clk25     (clk25),
    .RESETn    (RESETn),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rreq      (rreq),
    .wreq      (wreq),
    .addr_rw   (addr_rw),
    .data_com  (data_com),
    .com_done  (com_done),
    .data_read (data_read),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    RESETn = 1'b0; init_done = 1'b0; req_valid = '0; req_wr = '0;
    req_addr = '0; req_wdata = '0; com_done = 1'b0; data_read = '0;
    repeat (2) @(negedge clk25);
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rreq, wreq, addr_rw, data_com, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b rsp=%b rd=%h err=%b r=%b w=%b a=%h d=%h busy=%b expected all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, rreq, wreq, addr_rw, data_com, busy);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
    end
    RESETn = 1'b1;
    @(negedge clk25);
  endtask

  task automatic test_init_gate();
    int bad;
    bad = 0;
    req_wr = 3'b000; req_addr = 24'h0A_12_21; req_wdata = 24'hFF_80_44;
    req_valid = 3'b111;
    repeat (20) begin
      @(negedge clk25);
      if (req_ready !== 3'b000 || rreq !== 1'b0 || wreq !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL init_gate: got %0d granting cycles expected 0", bad);
    end
    init_done = 1'b1;
    @(negedge clk25);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++; $display("FAIL init_first_grant: got %b expected 001", req_ready);
    end
    checks++;
    if ({rreq, wreq, addr_rw, data_com} !== {1'b1, 1'b0, 8'h21, 8'h00}) begin
      failures++;
      $display("FAIL init_cmd: got r=%b w=%b a=%h d=%h expected r=1 w=0 a=21 d=00", rreq, wreq, addr_rw, data_com);
    end
    req_valid = 3'b000;
    @(negedge clk25);
    checks++;
    if (req_ready !== 3'b000 || rreq !== 1'b1) begin
      failures++; $display("FAIL ready_pulse: got rdy=%b r=%b expected rdy=000 r=1", req_ready, rreq);
    end
    com_done = 1'b1; data_read = 8'h5A;
    @(negedge clk25);
    com_done = 1'b0;
    checks++;
    if (rsp_valid !== 3'b001 || rsp_rdata !== 8'h5A || rreq !== 1'b0) begin
      failures++;
      $display("FAIL init_rsp: got rsp=%b rd=%h r=%b expected rsp=001 rd=5a r=0", rsp_valid, rsp_rdata, rreq);
    end
    @(negedge clk25);
    checks++;
    if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
      failures++; $display("FAIL rsp_pulse: got rsp=%b busy=%b expected rsp=000 busy=0", rsp_valid, busy);
    end
  endtask

  task automatic test_write();
    int bad;
    bad = 0;
    req_wr = 3'b010; req_addr[15:8] = 8'h12; req_wdata[15:8] = 8'h80;
    req_valid = 3'b010;
    @(negedge clk25);
    checks++;
    if ({req_ready, wreq, rreq, addr_rw, data_com, busy} !== {3'b010, 1'b1, 1'b0, 8'h12, 8'h80, 1'b1}) begin
      failures++;
      $display("FAIL write_issue: got rdy=%b w=%b r=%b a=%h d=%h busy=%b expected rdy=010 w=1 r=0 a=12 d=80 busy=1",
               req_ready, wreq, rreq, addr_rw, data_com, busy);
    end
    req_valid = 3'b000;
    repeat (3) begin
      @(negedge clk25);
      if (wreq !== 1'b1 || rreq !== 1'b0 || addr_rw !== 8'h12 || data_com !== 8'h80) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL write_hold: got %0d bad cycles expected 0", bad);
    end
    com_done = 1'b1; data_read = 8'hC3;
    @(negedge clk25);
    com_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, wreq} !== {3'b010, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL write_rsp: got rsp=%b rd=%h err=%b w=%b expected rsp=010 rd=00 err=0 w=0",
               rsp_valid, rsp_rdata, rsp_err, wreq);
    end
    @(negedge clk25);
  endtask

  task automatic test_read();
    int bad;
    bad = 0;
    req_wr = 3'b000; req_addr[23:16] = 8'h0A; req_wdata[23:16] = 8'hFF;
    req_valid = 3'b100;
    @(negedge clk25);
    checks++;
    if ({req_ready, rreq, wreq, addr_rw, data_com} !== {3'b100, 1'b1, 1'b0, 8'h0A, 8'h00}) begin
      failures++;
      $display("FAIL read_issue: got rdy=%b r=%b w=%b a=%h d=%h expected rdy=100 r=1 w=0 a=0a d=00",
               req_ready, rreq, wreq, addr_rw, data_com);
    end
    req_valid = 3'b000;
    repeat (5) begin
      @(negedge clk25);
      if (rreq !== 1'b1 || wreq !== 1'b0 || rsp_valid !== 3'b000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL read_hold: got %0d bad cycles expected 0", bad);
    end
    com_done = 1'b1; data_read = 8'h76;
    @(negedge clk25);
    com_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rreq} !== {3'b100, 8'h76, 1'b0}) begin
      failures++;
      $display("FAIL read_rsp: got rsp=%b rd=%h r=%b expected rsp=100 rd=76 r=0", rsp_valid, rsp_rdata, rreq);
    end
    @(negedge clk25);
  endtask

  task automatic test_back_to_back();
    int grants, rsps, cyc, eng, k;
    int order_bad, overlap_bad, rsp_bad, strobe_bad;
    logic outstanding;
    logic [7:0] exp_rd;
    grants = 0; rsps = 0; cyc = 0; eng = 0;
    order_bad = 0; overlap_bad = 0; rsp_bad = 0; strobe_bad = 0;
    outstanding = 1'b0;
    req_wr = 3'b101; req_addr = 24'h33_22_11; req_wdata = 24'hC0_B0_A0;
    data_read = 8'h3C; com_done = 1'b0;
    req_valid = 3'b111;
    while ((grants < 6 || rsps < 6) && cyc < 300) begin
      @(negedge clk25);
      cyc++;
      if (req_ready !== 3'b000) begin
        k = grants % 3;
        if (outstanding) overlap_bad++;
        if (req_ready !== (3'b001 << k)) order_bad++;
        if ({wreq, rreq} !== (req_wr[k] ? 2'b10 : 2'b01)) strobe_bad++;
        outstanding = 1'b1;
        grants++;
        if (grants == 6) req_valid = 3'b000;
      end
      if (rsp_valid !== 3'b000) begin
        k = rsps % 3;
        exp_rd = req_wr[k] ? 8'h00 : 8'h3C;
        if (!outstanding || rsp_valid !== (3'b001 << k) || rsp_rdata !== exp_rd) rsp_bad++;
        outstanding = 1'b0;
        rsps++;
      end
      if (com_done) com_done = 1'b0;
      else if (rreq || wreq) begin
        if (eng == 2) begin com_done = 1'b1; eng = 0; end
        else eng++;
      end
    end
    checks++;
    if (grants !== 6 || rsps !== 6) begin
      failures++; $display("FAIL b2b_count: got grants=%0d rsps=%0d expected 6/6", grants, rsps);
    end
    checks++;
    if (order_bad !== 0) begin
      failures++; $display("FAIL b2b_order: got %0d out-of-order grants expected 0", order_bad);
    end
    checks++;
    if (overlap_bad !== 0) begin
      failures++; $display("FAIL b2b_overlap: got %0d overlapping grants expected 0", overlap_bad);
    end
    checks++;
    if (rsp_bad !== 0 || strobe_bad !== 0) begin
      failures++; $display("FAIL b2b_rsp: got rsp_bad=%0d strobe_bad=%0d expected 0/0", rsp_bad, strobe_bad);
    end
    @(negedge clk25);
  endtask

`ifdef SCCB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int count;
    req_wr = 3'b000; data_read = 8'h99; com_done = 1'b0;
    req_valid = 3'b001;
    @(negedge clk25);
    checks++;
    if (req_ready !== 3'b001 || rreq !== 1'b1) begin
      failures++; $display("FAIL to_grant: got rdy=%b r=%b expected rdy=001 r=1", req_ready, rreq);
    end
    req_valid = 3'b000;
    count = 0;
    while (rreq === 1'b1 && count < 300) begin
      count++;
      @(negedge clk25);
    end
    checks++;
    if (count !== 100) begin
      failures++; $display("FAIL to_wait_len: got %0d expected 100", count);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b001, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL to_rsp: got rsp=%b err=%b rd=%h expected rsp=001 err=1 rd=00", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk25);
    req_valid = 3'b010;
    @(negedge clk25);
    req_valid = 3'b000;
    count = 1;
    while (count < 100) begin
      @(negedge clk25);
      count++;
    end
    checks++;
    if (rreq !== 1'b1) begin
      failures++; $display("FAIL to_edge_hold: got r=%b expected 1", rreq);
    end
    com_done = 1'b1;
    @(negedge clk25);
    com_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b010, 1'b0, 8'h99}) begin
      failures++;
      $display("FAIL to_edge_done: got rsp=%b err=%b rd=%h expected rsp=010 err=0 rd=99", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk25);
  endtask
`endif

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    req_wr = 3'b010; req_valid = 3'b010;
    @(negedge clk25);
    checks++;
    if (req_ready !== 3'b010 || wreq !== 1'b1) begin
      failures++; $display("FAIL rst_mid_grant: got rdy=%b w=%b expected rdy=010 w=1", req_ready, wreq);
    end
    req_valid = 3'b000;
    @(negedge clk25);
    #5 RESETn = 1'b0;
    #1;
    checks++;
    if ({wreq, rreq, busy} !== 3'b000 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL rst_mid_async: got w=%b r=%b busy=%b st=%0d expected 0 0 0 0", wreq, rreq, busy, state_dbg);
    end
    com_done = 1'b1;
    @(negedge clk25);
    com_done = 1'b0;
    RESETn = 1'b1;
    repeat (4) begin
      @(negedge clk25);
      if (rsp_valid !== 3'b000 || wreq !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL rst_mid_no_rsp: got %0d bad cycles expected 0", bad);
    end
    req_wr = 3'b000; req_valid = 3'b111;
    @(negedge clk25);
    checks++;
    if (req_ready !== 3'b001) begin
      failures++; $display("FAIL rst_mid_first_grant: got %b expected 001", req_ready);
    end
    req_valid = 3'b000;
    com_done = 1'b1;
    @(negedge clk25);
    com_done = 1'b0;
    @(negedge clk25);
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_write();
    test_read();
    test_back_to_back();
`ifdef SCCB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
